// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
//   state_t   : round sequencer FSM states
//   LFSR_TAPS : feedback mask for x^8+x^6+x^5+x^4+1 (shift-left Fibonacci form)
//   SCORE_W   : width of the score and miss counters
//   ROUND_W   : width of the round counter
package whack_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned ROUND_W = 5;

  // Bits 7,5,4,3 of the register feed the XOR for x^8, x^6, x^5, x^4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StShow,
    StHitFb,
    StMissFb,
    StGameOver
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/whack_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next hole.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset, loads SEED
//   lfsr : current register value, advances every cycle out of reset
module whack_lfsr8
  import whack_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer for the whack-a-mole game: picks a hole, raises the mole,
// drives the interval timer and scores each round as a hit or a miss.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle pulse, starts a game from idle or game over
//   hit           : one-cycle button pulses, one bit per hole
//   tmr_timeout   : one-cycle pulse from the interval timer
//   tmr_restart   : one-cycle reload pulse to the timer
//   tmr_run       : timer counts while high
//   tmr_interval  : timer interval in seconds
//   tmr_dir       : timer direction, always count down
//   mole          : one-hot active hole, zero when no mole is up
//   score, misses : saturating hit / miss counters
//   round         : rounds completed in the current game
//   busy          : game in progress
//   game_over     : game finished, counters held
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned NUM_HOLES      = 4,
  parameter int unsigned ROUNDS         = 16,
  parameter int unsigned START_INTERVAL = 5,
  parameter int unsigned MIN_INTERVAL   = 1,
  parameter int unsigned FB_CYCLES      = 25_000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit,
  input  logic                 tmr_timeout,
  output logic                 tmr_restart,
  output logic                 tmr_run,
  output logic [2:0]           tmr_interval,
  output logic                 tmr_dir,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [ROUND_W-1:0]   round,
  output logic                 busy,
  output logic                 game_over
);

  localparam int unsigned HOLE_W = $clog2(NUM_HOLES);
  localparam int unsigned FB_W   = (FB_CYCLES > 1) ? $clog2(FB_CYCLES) : 1;

  localparam logic [2:0]         START_INT = 3'(START_INTERVAL);
  localparam logic [2:0]         MIN_INT   = 3'(MIN_INTERVAL);
  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(ROUNDS);
  localparam logic [FB_W-1:0]    FB_LOAD   = FB_W'(FB_CYCLES - 1);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0 = {{(NUM_HOLES - 1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] CNT_MAX   = '1;

  state_t              state;
  logic [HOLE_W-1:0]   hole;
  logic [FB_W-1:0]     fb_cnt;
  logic [7:0]          lfsr;

  logic [NUM_HOLES-1:0] arm_onehot;
  logic [NUM_HOLES-1:0] hole_onehot;
  logic [SCORE_W-1:0]   score_inc;
  logic [SCORE_W-1:0]   misses_inc;
  logic [ROUND_W-1:0]   round_inc;
  logic                 harder;
  logic                 unused_lfsr;

  whack_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Only the low bits select a hole; the rest just keep the sequence long.
  assign unused_lfsr = ^lfsr;

  assign tmr_dir = 1'b0;

  always_comb begin
    arm_onehot  = ONE_HOT0 << lfsr[HOLE_W-1:0];
    hole_onehot = ONE_HOT0 << hole;
    score_inc   = (score == CNT_MAX) ? score : score + SCORE_W'(1);
    misses_inc  = (misses == CNT_MAX) ? misses : misses + SCORE_W'(1);
    round_inc   = round + ROUND_W'(1);
    // Every fourth correct hit shortens the interval, down to the floor.
    harder      = (score_inc[1:0] == 2'b00) && (score_inc != '0) &&
                  (tmr_interval > MIN_INT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      hole         <= '0;
      fb_cnt       <= '0;
      mole         <= '0;
      score        <= '0;
      misses       <= '0;
      round        <= '0;
      tmr_restart  <= 1'b0;
      tmr_run      <= 1'b0;
      tmr_interval <= START_INT;
      busy         <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      tmr_restart <= 1'b0;
      case (state)
        StIdle, StGameOver: begin
          if (start) begin
            score        <= '0;
            misses       <= '0;
            round        <= '0;
            tmr_interval <= START_INT;
            tmr_restart  <= 1'b1;
            busy         <= 1'b1;
            game_over    <= 1'b0;
            state        <= StArm;
          end
        end
        StArm: begin
          hole    <= lfsr[HOLE_W-1:0];
          mole    <= arm_onehot;
          tmr_run <= 1'b1;
          state   <= StShow;
        end
        StShow: begin
          // A button press wins over a coincident timeout.
          if (hit != '0) begin
            mole    <= '0;
            tmr_run <= 1'b0;
            fb_cnt  <= FB_LOAD;
            if (hit == hole_onehot) begin
              score <= score_inc;
              if (harder) begin
                tmr_interval <= tmr_interval - 3'd1;
              end
              state <= StHitFb;
            end else begin
              misses <= misses_inc;
              state  <= StMissFb;
            end
          end else if (tmr_timeout) begin
            mole    <= '0;
            tmr_run <= 1'b0;
            fb_cnt  <= FB_LOAD;
            misses  <= misses_inc;
            state   <= StMissFb;
          end
        end
        StHitFb, StMissFb: begin
          if (fb_cnt == '0) begin
            round <= round_inc;
            if (round_inc == LAST_RND) begin
              busy      <= 1'b0;
              game_over <= 1'b1;
              state     <= StGameOver;
            end else begin
              tmr_restart <= 1'b1;
              state       <= StArm;
            end
          end else begin
            fb_cnt <= fb_cnt - FB_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Directed self-checking bench for whack_round_ctrl (4 holes, 16 rounds,
// interval 5 down to a floor of 3, 4-cycle feedback pause).
module tb_whack_round_ctrl;

  localparam int FB     = 4;
  localparam int ROUNDS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] hit = 4'b0;
  logic       tmr_timeout = 1'b0;
  logic       tmr_restart, tmr_run, tmr_dir, busy, game_over;
  logic [2:0] tmr_interval;
  logic [3:0] mole;
  logic [7:0] score, misses;
  logic [4:0] round;

  int checks = 0;
  int errors = 0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, advancing every cycle.
  logic [7:0] lfsr_m;

  whack_round_ctrl #(
    .NUM_HOLES      (4),
    .ROUNDS         (ROUNDS),
    .START_INTERVAL (5),
    .MIN_INTERVAL   (3),
    .FB_CYCLES      (FB),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .hit          (hit),
    .tmr_timeout  (tmr_timeout),
    .tmr_restart  (tmr_restart),
    .tmr_run      (tmr_run),
    .tmr_interval (tmr_interval),
    .tmr_dir      (tmr_dir),
    .mole         (mole),
    .score        (score),
    .misses       (misses),
    .round        (round),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_hit(input logic [3:0] v, input logic to);
    hit = v;
    tmr_timeout = to;
    tick();
    hit = 4'b0;
    tmr_timeout = 1'b0;
  endtask

  // Waits for the mole to rise; the expected hole comes from the reference
  // LFSR value held during the restart (ARM) cycle.
  task automatic wait_show(output logic [3:0] e, output bit ok);
    ok = 1'b0;
    e  = 4'b0;
    for (int i = 0; i < 200; i++) begin
      if (tmr_restart) e = 4'b0001 << lfsr_m[1:0];
      if (mole != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [2:0] iv(input int s);
    if (s < 4) return 3'd5;
    if (s < 8) return 3'd4;
    return 3'd3;
  endfunction

  localparam logic [32:0] RESET_VEC =
    {4'h0, 8'h00, 8'h00, 5'h00, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    logic [32:0] obs;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    obs = {mole, score, misses, round, tmr_restart, tmr_run, tmr_interval, tmr_dir,
           busy, game_over};
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, RESET_VEC);
    end
    rst = 1'b0;
    tick();
    // Idle ignores hits and timeouts.
    pulse_hit(4'hF, 1'b1);
    tick();
    obs = {mole, score, misses, round, tmr_restart, tmr_run, tmr_interval, tmr_dir,
           busy, game_over};
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL idle_ignores_inputs: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_hit_game();
    logic [3:0] e;
    int low;
    pulse_start();
    checks++;
    if (tmr_restart !== 1'b1 || busy !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL start_arm: got restart=%b busy=%b go=%b expected 1 1 0",
               tmr_restart, busy, game_over);
    end
    for (int r = 0; r < ROUNDS; r++) begin
      // Here: ARM cycle, exactly one restart cycle before the mole rises.
      e = 4'b0001 << lfsr_m[1:0];
      checks++;
      if (mole !== 4'b0 || round !== 5'(r)) begin
        errors++;
        $display("FAIL arm_state r=%0d: got mole=%b round=%0d expected 0000 %0d",
                 r, mole, round, r);
      end
      tick();
      checks++;
      if (mole !== e || tmr_restart !== 1'b0 || tmr_run !== 1'b1 ||
          tmr_interval !== iv(r)) begin
        errors++;
        $display("FAIL show_entry r=%0d: got mole=%b rst=%b run=%b iv=%0d expected %b 0 1 %0d",
                 r, mole, tmr_restart, tmr_run, tmr_interval, e, iv(r));
      end
      tick();
      tick();
      pulse_hit(e, 1'b0);
      checks++;
      if (score !== 8'(r + 1) || misses !== 8'd0 || mole !== 4'b0 || tmr_run !== 1'b0 ||
          tmr_interval !== iv(r + 1)) begin
        errors++;
        $display("FAIL after_hit r=%0d: got score=%0d miss=%0d mole=%b run=%b iv=%0d expected %0d 0 0000 0 %0d",
                 r, score, misses, mole, tmr_run, tmr_interval, r + 1, iv(r + 1));
      end
      if (r < ROUNDS - 1) begin
        // Feedback pause: FB mole-free cycles before the next restart.
        low = 0;
        while (!tmr_restart && low < 50) begin
          low++;
          tick();
        end
        checks++;
        if (low != FB) begin
          errors++;
          $display("FAIL fb_pause r=%0d: got %0d cycles expected %0d", r, low, FB);
        end
      end else begin
        low = 0;
        while (!game_over && low < 50) begin
          low++;
          tick();
        end
      end
    end
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0 || score !== 8'd16 || misses !== 8'd0 ||
        round !== 5'd16 || tmr_interval !== 3'd3 || mole !== 4'b0) begin
      errors++;
      $display("FAIL game_end: got go=%b busy=%b score=%0d miss=%0d round=%0d iv=%0d expected 1 0 16 0 16 3",
               game_over, busy, score, misses, round, tmr_interval);
    end
  endtask

  task automatic test_timeout_and_collisions();
    logic [3:0] e;
    bit ok;
    // Restart from game over clears the counters.
    pulse_start();
    checks++;
    if (score !== 8'd0 || misses !== 8'd0 || round !== 5'd0 || game_over !== 1'b0 ||
        busy !== 1'b1 || tmr_restart !== 1'b1 || tmr_interval !== 3'd5) begin
      errors++;
      $display("FAIL restart_clear: got score=%0d miss=%0d round=%0d go=%b busy=%b rst=%b iv=%0d expected 0 0 0 0 1 1 5",
               score, misses, round, game_over, busy, tmr_restart, tmr_interval);
    end
    // Timeout on the fifth SHOW cycle.
    wait_show(e, ok);
    checks++;
    if (!ok || mole !== e) begin
      errors++;
      $display("FAIL timeout_round_mole: got %b ok=%0d expected %b", mole, ok, e);
    end
    repeat (4) tick();
    pulse_hit(4'b0, 1'b1);
    checks++;
    if (misses !== 8'd1 || score !== 8'd0 || mole !== 4'b0 || tmr_run !== 1'b0) begin
      errors++;
      $display("FAIL timeout_miss: got miss=%0d score=%0d mole=%b run=%b expected 1 0 0000 0",
               misses, score, mole, tmr_run);
    end
    // Correct hit together with timeout: hit wins.
    wait_show(e, ok);
    pulse_hit(e, 1'b1);
    checks++;
    if (!ok || score !== 8'd1 || misses !== 8'd1) begin
      errors++;
      $display("FAIL hit_with_timeout: got score=%0d miss=%0d ok=%0d expected 1 1",
               score, misses, ok);
    end
    // Correct bit plus a wrong bit counts as a miss.
    wait_show(e, ok);
    pulse_hit(e | {e[2:0], e[3]}, 1'b0);
    checks++;
    if (!ok || score !== 8'd1 || misses !== 8'd2) begin
      errors++;
      $display("FAIL double_bit_miss: got score=%0d miss=%0d ok=%0d expected 1 2",
               score, misses, ok);
    end
    // start while busy is ignored.
    wait_show(e, ok);
    pulse_start();
    checks++;
    if (!ok || mole !== e || busy !== 1'b1 || tmr_restart !== 1'b0 || round !== 5'd3 ||
        score !== 8'd1 || misses !== 8'd2) begin
      errors++;
      $display("FAIL start_in_show: got mole=%b busy=%b rst=%b round=%0d score=%0d miss=%0d expected %b 1 0 3 1 2",
               mole, busy, tmr_restart, round, score, misses, e);
    end
    pulse_hit(e, 1'b0);
    // Inputs during feedback are ignored.
    pulse_hit(4'hF, 1'b1);
    checks++;
    if (score !== 8'd2 || misses !== 8'd2 || round !== 5'd3 || mole !== 4'b0) begin
      errors++;
      $display("FAIL fb_ignores_inputs: got score=%0d miss=%0d round=%0d mole=%b expected 2 2 3 0000",
               score, misses, round, mole);
    end
  endtask

  task automatic test_reset_mid_show();
    logic [3:0] e;
    logic [32:0] obs;
    bit ok;
    wait_show(e, ok);
    checks++;
    if (!ok || mole !== e || round !== 5'd4) begin
      errors++;
      $display("FAIL pre_reset_show: got mole=%b round=%0d ok=%0d expected %b 4",
               mole, round, ok, e);
    end
    rst = 1'b1;
    tick();
    obs = {mole, score, misses, round, tmr_restart, tmr_run, tmr_interval, tmr_dir,
           busy, game_over};
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_mid_show: got %h expected %h", obs, RESET_VEC);
    end
    rst = 1'b0;
    repeat (3) tick();
    obs = {mole, score, misses, round, tmr_restart, tmr_run, tmr_interval, tmr_dir,
           busy, game_over};
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_hit_game();
    test_timeout_and_collisions();
    test_reset_mid_show();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
